// File: rtl/mem_wb_stage_skid_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_skid_pkg
//   Shared definitions for the MEM->WB pipeline register:
//     - default widths of the write-back payload fields
//     - write-back mux select encodings
//     - default-width write-back payload struct (field order matches the
//       packing used inside mem_wb_stage_skid)
//     - state enum of the two-entry skid buffer and an occupancy helper
// -----------------------------------------------------------------------------
package mem_wb_stage_skid_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int RD_W_DEF    = 5;
   localparam int WDSEL_W_DEF = 3;

   // Write-back mux select encodings.
   localparam logic [WDSEL_W_DEF-1:0] WD_ALU = 3'd0;
   localparam logic [WDSEL_W_DEF-1:0] WD_MEM = 3'd1;
   localparam logic [WDSEL_W_DEF-1:0] WD_PC4 = 3'd2;

   // Buffer state; the numeric value equals the number of held entries.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_t;

   // Write-back payload at the default widths, most significant field first.
   typedef struct packed {
      logic [DATA_W_DEF-1:0]  read_data;
      logic [DATA_W_DEF-1:0]  aluout;
      logic [RD_W_DEF-1:0]    rd;
      logic                   regwrite;
      logic [WDSEL_W_DEF-1:0] wdsel;
   } wb_payload_t;

   // Number of held entries for a given buffer state.
   function automatic logic [1:0] state_occupancy(skid_state_t s);
      logic [1:0] occ;
      case (s)
         ONE:     occ = 2'd1;
         TWO:     occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/mem_wb_stage_skid_pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
//   Generic, payload-agnostic valid/ready buffer holding up to two entries
//   (main + skid) with a synchronous flush.
//
//   Parameters
//     W        payload width
//     SKID_EN  1: two entries, in_ready is a pure function of the state
//                 register (no combinational path from out_ready)
//              0: single entry, in_ready = !out_valid | out_ready
//
//   Ports
//     clk, rst           clock (rising edge), asynchronous active-high reset
//     flush              drop all held entries and any same-cycle accept
//     in_valid/in_ready  upstream handshake, in_data payload
//     out_valid/out_ready downstream handshake, out_data = oldest entry
//     skid_valid/skid_data  second (younger) entry, for hazard inspection
//     occupancy          number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_skid_buf
   import mem_wb_stage_skid_pkg::*;
#(
   parameter int W       = 8,
   parameter bit SKID_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         skid_valid,
   output logic [W-1:0] skid_data,
   output logic [1:0]   occupancy
);

   skid_state_t  state_reg;
   skid_state_t  state_next;
   logic [W-1:0] main_reg;
   logic [W-1:0] skid_reg;
   logic         accept;
   logic         pop;

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         EMPTY: begin
            if (accept) begin
               state_next = ONE;
            end
         end
         ONE: begin
            if (pop && !accept) begin
               state_next = EMPTY;
            end else if (accept && !pop) begin
               state_next = TWO;
            end
         end
         TWO: begin
            if (pop) begin
               state_next = ONE;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
      if (flush) begin
         state_next = EMPTY;
      end
   end

   // Output logic.
   always_comb begin
      out_valid  = (state_reg != EMPTY);
      skid_valid = (state_reg == TWO);
      occupancy  = state_occupancy(state_reg);
      if (SKID_EN) begin
         in_ready = (state_reg != TWO);
      end else begin
         in_ready = (state_reg == EMPTY) | out_ready;
      end
   end

   // Payload storage. Cleared on reset so nothing stale is visible afterwards;
   // on flush the contents are don't-care because both valids drop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_reg <= '0;
         skid_reg <= '0;
      end else if (!flush) begin
         case (state_reg)
            EMPTY: begin
               if (accept) begin
                  main_reg <= in_data;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  main_reg <= in_data;
               end else if (accept) begin
                  skid_reg <= in_data;
               end
            end
            TWO: begin
               // in_ready is low here, so only the skid-to-main shift occurs.
               if (pop) begin
                  main_reg <= skid_reg;
               end
            end
            default: begin
               main_reg <= main_reg;
            end
         endcase
      end
   end

   assign out_data  = main_reg;
   assign skid_data = skid_reg;

endmodule

// File: rtl/mem_wb_stage_skid.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_skid
//   MEM->WB pipeline register with valid/ready handshake, optional skid entry,
//   synchronous flush and a hazard-visibility port.
//
//   Ports
//     clk, rst                  clock, asynchronous active-high reset
//     flush                     squash all held and incoming entries
//     in_valid/in_ready         MEM-side handshake
//     in_read_data, in_aluout, in_rd, in_regwrite, in_wdsel   MEM payload
//     out_valid/out_ready       WB-side handshake
//     out_read_data, out_aluout, out_rd, out_wdsel            held payload
//     out_regwrite              write enable qualified by out_valid
//     pend_rd_valid, pend_rd    oldest held entry that writes a nonzero reg
//     occupancy                 number of held entries (0..2)
// -----------------------------------------------------------------------------
module mem_wb_stage_skid
   import mem_wb_stage_skid_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int RD_W    = RD_W_DEF,
   parameter int WDSEL_W = WDSEL_W_DEF,
   parameter bit SKID_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_read_data,
   input  logic [DATA_W-1:0]  in_aluout,
   input  logic [RD_W-1:0]    in_rd,
   input  logic               in_regwrite,
   input  logic [WDSEL_W-1:0] in_wdsel,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_read_data,
   output logic [DATA_W-1:0]  out_aluout,
   output logic [RD_W-1:0]    out_rd,
   output logic               out_regwrite,
   output logic [WDSEL_W-1:0] out_wdsel,
   output logic               pend_rd_valid,
   output logic [RD_W-1:0]    pend_rd,
   output logic [1:0]         occupancy
);

   // Same field order as wb_payload_t, but sized by this instance's parameters.
   typedef struct packed {
      logic [DATA_W-1:0]  read_data;
      logic [DATA_W-1:0]  aluout;
      logic [RD_W-1:0]    rd;
      logic               regwrite;
      logic [WDSEL_W-1:0] wdsel;
   } payload_t;

   localparam int PAYLOAD_W = $bits(payload_t);

   payload_t               in_pl;
   payload_t               main_pl;
   payload_t               skid_pl;
   logic [PAYLOAD_W-1:0]   main_bits;
   logic [PAYLOAD_W-1:0]   skid_bits;
   logic                   skid_valid;
   logic                   main_writes;
   logic                   skid_writes;

   // Writes to x0 are dropped at capture, so nothing downstream (including
   // the hazard port) ever sees them as real writes.
   always_comb begin
      in_pl.read_data = in_read_data;
      in_pl.aluout    = in_aluout;
      in_pl.rd        = in_rd;
      in_pl.regwrite  = in_regwrite & (in_rd != '0);
      in_pl.wdsel     = in_wdsel;
   end

   pipe_skid_buf #(
      .W       (PAYLOAD_W),
      .SKID_EN (SKID_EN)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_pl),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (main_bits),
      .skid_valid (skid_valid),
      .skid_data  (skid_bits),
      .occupancy  (occupancy)
   );

   assign main_pl = main_bits;
   assign skid_pl = skid_bits;

   // Payload fields hold their last value while out_valid is low; only the
   // write enable is gated so WB never writes from a stale entry.
   assign out_read_data = main_pl.read_data;
   assign out_aluout    = main_pl.aluout;
   assign out_rd        = main_pl.rd;
   assign out_wdsel     = main_pl.wdsel;
   assign out_regwrite  = main_pl.regwrite & out_valid;

   // Hazard port: driven from held state only, the older (main) entry wins.
   always_comb begin
      main_writes   = out_valid & main_pl.regwrite;
      skid_writes   = skid_valid & skid_pl.regwrite;
      pend_rd_valid = main_writes | skid_writes;
      if (main_writes) begin
         pend_rd = main_pl.rd;
      end else if (skid_writes) begin
         pend_rd = skid_pl.rd;
      end else begin
         pend_rd = '0;
      end
   end

   // The hazard logic only needs rd/regwrite of the skid entry.
   logic unused_skid_fields;
   assign unused_skid_fields = ^{skid_pl.read_data, skid_pl.aluout, skid_pl.wdsel};

endmodule

// File: tb/tb_mem_wb_stage_skid.sv
module tb_mem_wb_stage_skid;
   import mem_wb_stage_skid_pkg::*;

   typedef struct {
      logic        ready, valid, regwrite, pvalid;
      logic [31:0] read_data, aluout;
      logic [4:0]  rd, prd;
      logic [2:0]  wdsel;
      logic [1:0]  occ;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   wb_payload_t cur = '0;

   logic        r1, v1, rw1, pv1, r0, v0, rw0, pv0;
   logic [31:0] rdat1, alu1, rdat0, alu0;
   logic [4:0]  rdi1, prd1, rdi0, prd0;
   logic [2:0]  ws1, ws0;
   logic [1:0]  oc1, oc0;

   int passed = 0, fails = 0, total = 0;
   wb_payload_t q1[$], q0[$];          // reference contents, oldest first
   logic [31:0] pop_log1[$], pop_log0[$];
   bit          last_acc1, last_acc0;
   int          n, beats;

   always #5 clk = ~clk;

   mem_wb_stage_skid #(.DATA_W(32), .RD_W(5), .WDSEL_W(3), .SKID_EN(1'b1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r1),
      .in_read_data(cur.read_data), .in_aluout(cur.aluout), .in_rd(cur.rd),
      .in_regwrite(cur.regwrite), .in_wdsel(cur.wdsel), .out_valid(v1),
      .out_ready(out_ready), .out_read_data(rdat1), .out_aluout(alu1), .out_rd(rdi1),
      .out_regwrite(rw1), .out_wdsel(ws1), .pend_rd_valid(pv1), .pend_rd(prd1),
      .occupancy(oc1));

   mem_wb_stage_skid #(.DATA_W(32), .RD_W(5), .WDSEL_W(3), .SKID_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r0),
      .in_read_data(cur.read_data), .in_aluout(cur.aluout), .in_rd(cur.rd),
      .in_regwrite(cur.regwrite), .in_wdsel(cur.wdsel), .out_valid(v0),
      .out_ready(out_ready), .out_read_data(rdat0), .out_aluout(alu0), .out_rd(rdi0),
      .out_regwrite(rw0), .out_wdsel(ws0), .pend_rd_valid(pv0), .pend_rd(prd0),
      .occupancy(oc0));

   function automatic obs_t get_obs(bit k);
      obs_t o;
      if (k) begin
         o.ready = r1; o.valid = v1; o.regwrite = rw1; o.pvalid = pv1;
         o.read_data = rdat1; o.aluout = alu1; o.rd = rdi1; o.prd = prd1;
         o.wdsel = ws1; o.occ = oc1;
      end else begin
         o.ready = r0; o.valid = v0; o.regwrite = rw0; o.pvalid = pv0;
         o.read_data = rdat0; o.aluout = alu0; o.rd = rdi0; o.prd = prd0;
         o.wdsel = ws0; o.occ = oc0;
      end
      return o;
   endfunction

   function automatic wb_payload_t mk(logic [31:0] rdat, logic [31:0] alu, logic [4:0] rd,
                                      logic rw, logic [2:0] ws);
      wb_payload_t p;
      p.read_data = rdat; p.aluout = alu; p.rd = rd; p.regwrite = rw; p.wdsel = ws;
      return p;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare one DUT against its reference queue; report the handshakes the
   // rules imply for this cycle.
   task automatic check_one(string p, bit k, output bit acc, output bit pop);
      obs_t        o;
      wb_payload_t q[$];
      bit          ev, er, pv;
      logic [4:0]  prd;
      o = get_obs(k);
      if (k) q = q1; else q = q0;
      ev = (q.size() != 0);
      er = k ? (q.size() < 2) : (q.size() == 0 || out_ready);
      pv = 1'b0;
      prd = 5'd0;
      foreach (q[i]) if (q[i].regwrite && !pv) begin pv = 1'b1; prd = q[i].rd; end
      chk({p, ".in_ready"}, 32'(o.ready), 32'(er));
      chk({p, ".out_valid"}, 32'(o.valid), 32'(ev));
      chk({p, ".occupancy"}, 32'(o.occ), 32'(q.size()));
      chk({p, ".out_regwrite"}, 32'(o.regwrite), ev ? 32'(q[0].regwrite) : 32'd0);
      chk({p, ".pend_rd_valid"}, 32'(o.pvalid), 32'(pv));
      chk({p, ".pend_rd"}, 32'(o.prd), 32'(prd));
      if (ev) begin
         chk({p, ".out_read_data"}, o.read_data, q[0].read_data);
         chk({p, ".out_aluout"}, o.aluout, q[0].aluout);
         chk({p, ".out_rd"}, 32'(o.rd), 32'(q[0].rd));
         chk({p, ".out_wdsel"}, 32'(o.wdsel), 32'(q[0].wdsel));
      end
      acc = in_valid && er;
      pop = ev && out_ready;
   endtask

   // One clock cycle: inputs are already driven; check, clock, update models.
   task automatic step();
      bit a1, p1, a0, p0;
      wb_payload_t it;
      #2;
      check_one("skid1", 1'b1, a1, p1);
      check_one("skid0", 1'b0, a0, p0);
      it = cur;
      it.regwrite = cur.regwrite && (cur.rd != 5'd0);
      @(posedge clk);
      #1;
      if (p1) pop_log1.push_back(q1[0].aluout);
      if (p0) pop_log0.push_back(q0[0].aluout);
      if (flush) begin
         q1.delete();
         q0.delete();
      end else begin
         if (p1) void'(q1.pop_front());
         if (a1) q1.push_back(it);
         if (p0) void'(q0.pop_front());
         if (a0) q0.push_back(it);
      end
      last_acc1 = a1;
      last_acc0 = a0;
   endtask

   task automatic check_reset_outputs(string p, bit k);
      obs_t o;
      o = get_obs(k);
      chk({p, ".in_ready"}, 32'(o.ready), 32'd1);
      chk({p, ".out_valid"}, 32'(o.valid), 32'd0);
      chk({p, ".out_read_data"}, o.read_data, 32'd0);
      chk({p, ".out_aluout"}, o.aluout, 32'd0);
      chk({p, ".out_rd"}, 32'(o.rd), 32'd0);
      chk({p, ".out_regwrite"}, 32'(o.regwrite), 32'd0);
      chk({p, ".out_wdsel"}, 32'(o.wdsel), 32'd0);
      chk({p, ".pend_rd_valid"}, 32'(o.pvalid), 32'd0);
      chk({p, ".pend_rd"}, 32'(o.prd), 32'd0);
      chk({p, ".occupancy"}, 32'(o.occ), 32'd0);
   endtask

   // Asynchronous reset raised mid-cycle; outputs must clear before any edge.
   task automatic reset_pulse();
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("rst1", 1'b1);
      check_reset_outputs("rst0", 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      q1.delete();
      q0.delete();
   endtask

   initial begin
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      reset_pulse();

      // Single transfer
      cur = mk(32'h0, 32'h0000_1234, 5'd5, 1'b1, WD_ALU);
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      #2;
      chk("single.out_valid", 32'(v1), 32'd1);
      chk("single.out_aluout", alu1, 32'h1234);
      chk("single.out_rd", 32'(rdi1), 32'd5);
      chk("single.out_regwrite", 32'(rw1), 32'd1);
      chk("single.occupancy", 32'(oc1), 32'd1);
      step();

      // x0 suppression
      cur = mk(32'hDEAD_BEEF, 32'h55, 5'd0, 1'b1, WD_MEM);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      #2;
      chk("x0.out_valid", 32'(v1), 32'd1);
      chk("x0.out_regwrite", 32'(rw1), 32'd0);
      chk("x0.pend_rd_valid", 32'(pv1), 32'd0);
      step();

      // Back-pressure: A, B accepted, C held off until space frees
      pop_log1.delete();
      out_ready = 1'b0; in_valid = 1'b1;
      cur = mk(32'h1, 32'hA0, 5'd7, 1'b1, WD_ALU); step();
      cur = mk(32'h2, 32'hB0, 5'd9, 1'b1, WD_MEM); step();
      cur = mk(32'h3, 32'hC0, 5'd11, 1'b1, WD_PC4);
      #2;
      chk("bp.occupancy", 32'(oc1), 32'd2);
      chk("bp.in_ready", 32'(r1), 32'd0);
      chk("bp.pend_rd", 32'(prd1), 32'd7);
      step(); step();
      out_ready = 1'b1;
      n = 0;
      last_acc1 = 1'b0;
      while (!last_acc1 && n < 8) begin step(); n++; end
      chk("bp.c_accepted", 32'(last_acc1), 32'd1);
      in_valid = 1'b0;
      repeat (4) step();
      chk("bp.pop_count", 32'(pop_log1.size()), 32'd3);
      if (pop_log1.size() == 3) begin
         chk("bp.order0", pop_log1[0], 32'hA0);
         chk("bp.order1", pop_log1[1], 32'hB0);
         chk("bp.order2", pop_log1[2], 32'hC0);
      end

      // Hazard priority: main rd 7 shadows skid rd 9
      out_ready = 1'b0; in_valid = 1'b1;
      cur = mk(32'h4, 32'h70, 5'd7, 1'b1, WD_ALU); step();
      cur = mk(32'h5, 32'h90, 5'd9, 1'b1, WD_ALU); step();
      in_valid = 1'b0;
      #2 chk("haz.pend_rd_main", 32'(prd1), 32'd7);
      out_ready = 1'b1;
      step();
      #2 chk("haz.pend_rd_skid", 32'(prd1), 32'd9);
      step();
      #2;
      chk("haz.pend_rd_valid_empty", 32'(pv1), 32'd0);
      chk("haz.pend_rd_empty", 32'(prd1), 32'd0);
      step();

      // Flush with simultaneous accept
      out_ready = 1'b0; in_valid = 1'b1;
      cur = mk(32'h6, 32'hD0, 5'd3, 1'b1, WD_MEM); step();
      cur = mk(32'h7, 32'hE0, 5'd4, 1'b1, WD_MEM); step();
      #2 chk("flush.occ_before", 32'(oc1), 32'd2);
      flush = 1'b1;
      cur = mk(32'h8, 32'hF0, 5'd6, 1'b1, WD_ALU);
      step();
      flush = 1'b0; in_valid = 1'b0;
      #2;
      chk("flush.occupancy", 32'(oc1), 32'd0);
      chk("flush.out_valid", 32'(v1), 32'd0);
      chk("flush.out_regwrite", 32'(rw1), 32'd0);
      chk("flush.in_ready", 32'(r1), 32'd1);
      out_ready = 1'b1;
      repeat (2) step();

      // Asynchronous reset while entries are held
      out_ready = 1'b0; in_valid = 1'b1;
      cur = mk(32'h9, 32'h1111, 5'd12, 1'b1, WD_ALU); step();
      cur = mk(32'hA, 32'h2222, 5'd13, 1'b1, WD_MEM); step();
      in_valid = 1'b0;
      reset_pulse();

      // Randomised traffic with occasional flush
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         cur.read_data = $urandom;
         cur.aluout    = $urandom;
         cur.rd        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         cur.regwrite  = 1'($urandom);
         cur.wdsel     = 3'($urandom_range(0, 2));
         step();
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) step();

      // Streaming into the single-entry variant, out_ready toggling
      pop_log0.delete();
      in_valid = 1'b1; out_ready = 1'b1;
      beats = 0; n = 0;
      while (beats < 100 && n < 400) begin
         cur = mk(32'(beats), 32'h1000 + 32'(beats), 5'(beats % 32), 1'b1, WD_ALU);
         step();
         chk("stream.occ0_le1", 32'(oc0 <= 2'd1), 32'd1);
         if (last_acc0) beats++;
         out_ready = ~out_ready;
         n++;
      end
      chk("stream.beats", 32'(beats), 32'd100);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) step();
      chk("stream.emitted", 32'(pop_log0.size()), 32'd100);
      foreach (pop_log0[i]) begin
         if (pop_log0[i] !== 32'h1000 + 32'(i))
            chk("stream.order", pop_log0[i], 32'h1000 + 32'(i));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
